// File: rtl/mem_lsu_pkg.sv
// Shared widths, opcodes and LSU state encodings for the memory-stage load/store unit.
package mem_lsu_pkg;
  localparam int RegBus      = 32;
  localparam int RegAddrBus  = 5;
  localparam int AluOpBus    = 8;
  localparam int InstAddrBus = 32;

  localparam logic                  Enable     = 1'b1;
  localparam logic                  Disable    = 1'b0;
  localparam logic [RegBus-1:0]     ZeroWord   = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

  localparam logic [AluOpBus-1:0] EXE_ADD_OP = 8'b00100000;
  localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'b11100000;
  localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'b11100100;
  localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'b11100001;
  localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'b11100101;
  localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'b11100011;
  localparam logic [AluOpBus-1:0] EXE_SB_OP  = 8'b11101000;
  localparam logic [AluOpBus-1:0] EXE_SH_OP  = 8'b11101001;
  localparam logic [AluOpBus-1:0] EXE_SW_OP  = 8'b11101011;

  localparam logic [1:0] LSU_IDLE = 2'd0;
  localparam logic [1:0] LSU_BUSY = 2'd1;
  localparam logic [1:0] LSU_DONE = 2'd2;

  function automatic logic is_load(input logic [AluOpBus-1:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  endfunction

  function automatic logic is_store(input logic [AluOpBus-1:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction
endpackage

// File: rtl/mem_lsu_if.sv
// Single-outstanding req/ack data bus between the LSU (master) and memory (slave).
interface mem_lsu_if;
  import mem_lsu_pkg::*;
  logic              req;
  logic              we;
  logic [RegBus-1:0] addr;
  logic [3:0]        sel;
  logic [RegBus-1:0] wdata;
  logic [RegBus-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, sel, wdata, input rdata, ack);
  modport slave  (input req, we, addr, sel, wdata, output rdata, ack);
endinterface

// File: rtl/mem_lsu_lane.sv
// Byte-lane steering: big-endian select, store replication and load extension.
module mem_lsu_lane
  import mem_lsu_pkg::*;
(
  input  logic [AluOpBus-1:0] aluop,
  input  logic [1:0]          addr_lo,
  input  logic [RegBus-1:0]   st_data,
  input  logic [RegBus-1:0]   rdata,
  output logic [3:0]          sel,
  output logic [RegBus-1:0]   st_word,
  output logic [RegBus-1:0]   ld_word
);
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  always_comb begin
    // lane 0 of the address is the most significant byte
    case (addr_lo)
      2'b00:   ld_b = rdata[31:24];
      2'b01:   ld_b = rdata[23:16];
      2'b10:   ld_b = rdata[15:8];
      default: ld_b = rdata[7:0];
    endcase
    ld_h = addr_lo[1] ? rdata[15:0] : rdata[31:16];

    sel     = 4'b0000;
    st_word = st_data;
    ld_word = rdata;
    case (aluop)
      EXE_LB_OP:  begin sel = 4'b1000 >> addr_lo; ld_word = {{24{ld_b[7]}}, ld_b}; end
      EXE_LBU_OP: begin sel = 4'b1000 >> addr_lo; ld_word = {24'b0, ld_b}; end
      EXE_LH_OP:  begin sel = addr_lo[1] ? 4'b0011 : 4'b1100; ld_word = {{16{ld_h[15]}}, ld_h}; end
      EXE_LHU_OP: begin sel = addr_lo[1] ? 4'b0011 : 4'b1100; ld_word = {16'b0, ld_h}; end
      EXE_LW_OP:  sel = 4'b1111;
      EXE_SB_OP:  begin sel = 4'b1000 >> addr_lo; st_word = {4{st_data[7:0]}}; end
      EXE_SH_OP:  begin sel = addr_lo[1] ? 4'b0011 : 4'b1100; st_word = {2{st_data[15:0]}}; end
      EXE_SW_OP:  sel = 4'b1111;
      default:    ;
    endcase
  end
endmodule

// File: rtl/mem_lsu.sv
// Memory-stage LSU: passes ALU results to MEM/WB and runs one bus transaction per load/store.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [InstAddrBus-1:0] pc_i,
  input  logic [RegAddrBus-1:0]  wd_i,
  input  logic                   wreg_i,
  input  logic [RegBus-1:0]      wdata_i,
  input  logic                   whilo_i,
  input  logic [RegBus-1:0]      hi_i,
  input  logic [RegBus-1:0]      lo_i,
  input  logic [AluOpBus-1:0]    aluop_i,
  input  logic [RegBus-1:0]      mem_addr_i,
  input  logic [RegBus-1:0]      mem_data_i,
  input  logic [5:0]             stall,
  output logic [InstAddrBus-1:0] pc_o,
  output logic [RegAddrBus-1:0]  wd_o,
  output logic                   wreg_o,
  output logic [RegBus-1:0]      wdata_o,
  output logic                   whilo_o,
  output logic [RegBus-1:0]      hi_o,
  output logic [RegBus-1:0]      lo_o,
  output logic                   stallreq_o,
  mem_lsu_if.master              bus
);
  logic [1:0]        state;
  logic [RegBus-1:0] rdata_q;
  logic              ld_op, mem_op;
  logic [3:0]        lane_sel;
  logic [RegBus-1:0] lane_st, lane_ld;
  logic              unused_stall;

  assign ld_op        = is_load(aluop_i);
  assign mem_op       = ld_op | is_store(aluop_i);
  assign unused_stall = ^{stall[5], stall[3:0]};

  mem_lsu_lane u_lane (
    .aluop   (aluop_i),
    .addr_lo (mem_addr_i[1:0]),
    .st_data (mem_data_i),
    .rdata   (bus.rdata),
    .sel     (lane_sel),
    .st_word (lane_st),
    .ld_word (lane_ld)
  );

  always_comb begin
    pc_o       = ZeroWord;
    wd_o       = NOPRegAddr;
    wreg_o     = Disable;
    wdata_o    = ZeroWord;
    whilo_o    = Disable;
    hi_o       = ZeroWord;
    lo_o       = ZeroWord;
    stallreq_o = Disable;
    if (rst != Enable) begin
      pc_o       = pc_i;
      wd_o       = wd_i;
      wreg_o     = wreg_i;
      whilo_o    = whilo_i;
      hi_o       = hi_i;
      lo_o       = lo_i;
      wdata_o    = (state == LSU_DONE && ld_op) ? rdata_q : wdata_i;
      stallreq_o = (state == LSU_IDLE && mem_op) || (state == LSU_BUSY);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == Enable) begin
      state     <= LSU_IDLE;
      rdata_q   <= ZeroWord;
      bus.req   <= 1'b0;
      bus.we    <= 1'b0;
      bus.addr  <= ZeroWord;
      bus.sel   <= 4'b0000;
      bus.wdata <= ZeroWord;
    end else begin
      case (state)
        LSU_IDLE: if (mem_op) begin
          bus.req   <= 1'b1;
          bus.we    <= ~ld_op;
          bus.addr  <= {mem_addr_i[31:2], 2'b00};
          bus.sel   <= lane_sel;
          bus.wdata <= lane_st;
          state     <= LSU_BUSY;
        end
        LSU_BUSY: if (bus.ack) begin
          bus.req <= 1'b0;
          bus.we  <= 1'b0;
          if (ld_op) rdata_q <= lane_ld;
          state   <= LSU_DONE;
        end
        // result is held until the pipeline lets the instruction leave MEM
        LSU_DONE: if (stall[4] == Disable) state <= LSU_IDLE;
        default:  state <= LSU_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a result scoreboard and bus-side ack driver.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i, wdata_i, hi_i, lo_i, mem_addr_i, mem_data_i;
  logic [4:0]  wd_i;
  logic        wreg_i, whilo_i;
  logic [7:0]  aluop_i;
  logic [5:0]  stall;
  logic [31:0] pc_o, wdata_o, hi_o, lo_o;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, stallreq_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  mem_lsu_if bus ();

  mem_lsu dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .whilo_i(whilo_i), .hi_i(hi_i), .lo_i(lo_i), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .stall(stall), .pc_o(pc_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Issues one load/store starting in IDLE; ack arrives in the n-th BUSY cycle.
  task automatic run_mem(input string tag, input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] rd, input int n,
                         input logic [3:0] esel, input logic ewe, input logic [31:0] ebw,
                         input logic [31:0] eres);
    int stalls = 0;
    aluop_i    = op;
    mem_addr_i = addr;
    mem_data_i = data;
    wdata_i    = 32'h5555_0000;
    sb_q.push_back(eres);
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      if (stallreq_o) stalls++;
      if (k == 0) chk({tag, " req_idle"}, 32'(bus.req), 32'd0);
      else begin
        chk({tag, " req"},   32'(bus.req), 32'd1);
        chk({tag, " addr"},  bus.addr, {addr[31:2], 2'b00});
        chk({tag, " sel"},   32'(bus.sel), 32'(esel));
        chk({tag, " we"},    32'(bus.we), 32'(ewe));
        chk({tag, " bwdat"}, bus.wdata, ebw);
      end
      if (k == n) begin
        bus.rdata = rd;
        bus.ack   = 1'b1;
      end
      next();
      bus.ack = 1'b0;
    end
    @(negedge clk);
    chk({tag, " stalls"},   32'(stalls), 32'(n + 1));
    chk({tag, " stallreq"}, 32'(stallreq_o), 32'd0);
    chk({tag, " req_done"}, 32'(bus.req), 32'd0);
    chk({tag, " we_done"},  32'(bus.we), 32'd0);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty observed=%h", tag, wdata_o);
    end else chk({tag, " result"}, wdata_o, sb_q.pop_front());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pc_i = 32'h0000_0400; wd_i = 5'd3; wreg_i = 1'b1; whilo_i = 1'b1;
    hi_i = 32'h1111_2222; lo_i = 32'h3333_4444; wdata_i = 32'h1234;
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h100; mem_data_i = '0; stall = '0;
    bus.ack = 1'b0; bus.rdata = '0;

    next(); next();
    @(negedge clk);
    chk("rst stallreq", 32'(stallreq_o), 32'd0);
    chk("rst pc",       pc_o, 32'd0);
    chk("rst wd",       32'(wd_o), 32'(NOPRegAddr));
    chk("rst wreg",     32'(wreg_o), 32'd0);
    chk("rst wdata",    wdata_o, 32'd0);
    chk("rst hi",       hi_o, 32'd0);
    chk("rst req",      32'(bus.req), 32'd0);
    chk("rst sel",      32'(bus.sel), 32'd0);
    chk("rst addr",     bus.addr, 32'd0);

    next();
    rst = 1'b0; aluop_i = EXE_ADD_OP; wdata_i = 32'h1234;
    @(negedge clk);
    chk("alu wdata",    wdata_o, 32'h1234);
    chk("alu stallreq", 32'(stallreq_o), 32'd0);
    chk("alu req",      32'(bus.req), 32'd0);
    chk("alu pc",       pc_o, 32'h0000_0400);
    chk("alu wd",       32'(wd_o), 32'd3);
    chk("alu hi",       hi_o, 32'h1111_2222);
    chk("alu lo",       lo_o, 32'h3333_4444);
    chk("alu whilo",    32'(whilo_o), 32'd1);
    next();
    @(negedge clk);
    chk("alu req2", 32'(bus.req), 32'd0);

    next();
    run_mem("lw",  EXE_LW_OP,  32'h100, 32'h0, 32'hDEAD_BEEF, 1, 4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF);
    next();
    run_mem("lb",  EXE_LB_OP,  32'h103, 32'h0, 32'h0000_00F0, 1, 4'b0001, 1'b0, 32'h0, 32'hFFFF_FFF0);
    next();
    run_mem("lbu", EXE_LBU_OP, 32'h103, 32'h0, 32'h0000_00F0, 1, 4'b0001, 1'b0, 32'h0, 32'h0000_00F0);
    next();
    run_mem("sh",  EXE_SH_OP,  32'h202, 32'hAAAA_5678, 32'h0, 3, 4'b0011, 1'b1, 32'h5678_5678, 32'h5555_0000);
    next();
    run_mem("sb",  EXE_SB_OP,  32'h101, 32'h1234_56AB, 32'h0, 2, 4'b0100, 1'b1, 32'hABAB_ABAB, 32'h5555_0000);
    next();
    run_mem("sw",  EXE_SW_OP,  32'h20B, 32'hCAFE_F00D, 32'h0, 1, 4'b1111, 1'b1, 32'hCAFE_F00D, 32'h5555_0000);
    next();
    run_mem("lhu", EXE_LHU_OP, 32'h003, 32'h0, 32'h1234_8765, 1, 4'b0011, 1'b0, 32'h0, 32'h0000_8765);

    // reset while BUSY, then a stray ack
    next();
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h300; wdata_i = 32'h5555_0000;
    next();
    @(negedge clk);
    chk("mrst busy req", 32'(bus.req), 32'd1);
    rst = 1'b1; aluop_i = EXE_ADD_OP; wdata_i = 32'h77;
    #1;
    chk("mrst stallreq", 32'(stallreq_o), 32'd0);
    chk("mrst wdata",    wdata_o, 32'd0);
    next();
    rst = 1'b0; bus.ack = 1'b1; bus.rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("mrst req",      32'(bus.req), 32'd0);
    chk("mrst stallreq2", 32'(stallreq_o), 32'd0);
    chk("mrst wdata2",   wdata_o, 32'h77);
    next();
    bus.ack = 1'b0;
    @(negedge clk);
    chk("mrst req3",     32'(bus.req), 32'd0);
    chk("mrst stallreq3", 32'(stallreq_o), 32'd0);
    chk("mrst wdata3",   wdata_o, 32'h77);

    // hold in DONE under downstream stall
    next();
    stall = 6'b010000;
    run_mem("lh", EXE_LH_OP, 32'h001, 32'h0, 32'h8765_1234, 1, 4'b1100, 1'b0, 32'h0, 32'hFFFF_8765);
    for (int i = 0; i < 2; i++) begin
      next();
      @(negedge clk);
      chk("hold stallreq", 32'(stallreq_o), 32'd0);
      chk("hold req",      32'(bus.req), 32'd0);
      chk("hold wdata",    wdata_o, 32'hFFFF_8765);
    end
    stall = '0;
    next();
    aluop_i = EXE_ADD_OP; wdata_i = 32'h99;
    @(negedge clk);
    chk("rel wdata",    wdata_o, 32'h99);
    chk("rel req",      32'(bus.req), 32'd0);
    chk("rel stallreq", 32'(stallreq_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
